// File: rtl/load_store_unit_v2_if.sv
// Operation codes shared by the load/store unit and its clients, plus the bundled
// LSB / memory-controller / CDB / ROB signal interface.
package lsu_v2_pkg;
    localparam int unsigned OP_LB  = 0;
    localparam int unsigned OP_LH  = 1;
    localparam int unsigned OP_LW  = 2;
    localparam int unsigned OP_LBU = 3;
    localparam int unsigned OP_LHU = 4;
    localparam int unsigned OP_SB  = 5;
    localparam int unsigned OP_SH  = 6;
    localparam int unsigned OP_SW  = 7;
endpackage

interface load_store_unit_v2_if #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6
);
    logic              enable_from_lsb;
    logic              read_write_flag_from_lsb;
    logic [OP_W-1:0]   op_enum_from_lsb;
    logic [ADDR_W-1:0] object_address_from_lsb;
    logic [31:0]       data_from_lsb;
    logic [TAG_W-1:0]  rob_tag_from_lsb;
    logic              busy_to_lsb;
    logic              end_to_lsb;
    logic [31:0]       data_to_lsb;
    logic              end_from_memcont;
    logic [31:0]       data_from_memcont;
    logic              enable_to_memcont;
    logic              read_write_flag_to_memcont;
    logic [ADDR_W-1:0] address_to_memcont;
    logic [1:0]        size_to_memcont;
    logic [31:0]       data_to_memcont;
    logic              enable_to_cdb;
    logic [31:0]       result_to_cdb;
    logic [TAG_W-1:0]  rob_tag_to_cdb;
    logic              fault_to_cdb;
    logic              rollback_flag_from_rob;

    // The load/store unit itself.
    modport slave (
        input  enable_from_lsb, read_write_flag_from_lsb, op_enum_from_lsb,
               object_address_from_lsb, data_from_lsb, rob_tag_from_lsb,
               end_from_memcont, data_from_memcont, rollback_flag_from_rob,
        output busy_to_lsb, end_to_lsb, data_to_lsb, enable_to_memcont,
               read_write_flag_to_memcont, address_to_memcont, size_to_memcont,
               data_to_memcont, enable_to_cdb, result_to_cdb, rob_tag_to_cdb, fault_to_cdb
    );

    // The surrounding LSB, memory controller and ROB.
    modport master (
        output enable_from_lsb, read_write_flag_from_lsb, op_enum_from_lsb,
               object_address_from_lsb, data_from_lsb, rob_tag_from_lsb,
               end_from_memcont, data_from_memcont, rollback_flag_from_rob,
        input  busy_to_lsb, end_to_lsb, data_to_lsb, enable_to_memcont,
               read_write_flag_to_memcont, address_to_memcont, size_to_memcont,
               data_to_memcont, enable_to_cdb, result_to_cdb, rob_tag_to_cdb, fault_to_cdb
    );
endinterface

// File: rtl/load_store_unit_v2.sv
// Single-request load/store unit: latches one LSB request, drives the memory
// controller, and broadcasts extended load results or misalignment faults on the CDB.
module load_store_unit_v2 #(
    parameter int ADDR_W         = 32,
    parameter int TAG_W          = 4,
    parameter int OP_W           = 6,
    parameter int MISALIGN_CHECK = 1
) (
    input logic                 clk_in,
    input logic                 rst_in,
    input logic                 rdy_in,
    load_store_unit_v2_if.slave bus
);
    import lsu_v2_pkg::*;

    typedef enum logic [1:0] {IDLE, ACCESS, KILL, FAULT} state_t;

    typedef struct packed {
        logic              busy;
        logic              end_pulse;
        logic [31:0]       data_to_lsb;
        logic              mem_en;
        logic              mem_rw;
        logic [ADDR_W-1:0] mem_addr;
        logic [1:0]        mem_size;
        logic [31:0]       mem_data;
        logic              cdb_en;
        logic [31:0]       cdb_result;
        logic [TAG_W-1:0]  cdb_tag;
        logic              cdb_fault;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  tag;
    } regs_t;

    state_t state, state_d;
    regs_t  r, r_d;
    logic   is_load;

    function automatic logic is_op(input logic [OP_W-1:0] op, input int unsigned code);
        return op == OP_W'(code);
    endfunction

    function automatic logic [1:0] size_of(input logic [OP_W-1:0] op);
        if (is_op(op, OP_LW) || is_op(op, OP_SW)) return 2'd2;
        if (is_op(op, OP_LH) || is_op(op, OP_LHU) || is_op(op, OP_SH)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic misaligned(input logic [OP_W-1:0] op, input logic [1:0] a);
        return (size_of(op) == 2'd1 && a[0]) || (size_of(op) == 2'd2 && a != 2'b00);
    endfunction

    function automatic logic [31:0] store_ext(input logic [OP_W-1:0] op, input logic [31:0] d);
        if (is_op(op, OP_SB)) return {24'b0, d[7:0]};
        if (is_op(op, OP_SH)) return {16'b0, d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] load_ext(input logic [OP_W-1:0] op, input logic [31:0] d);
        if (is_op(op, OP_LB))  return {{24{d[7]}}, d[7:0]};
        if (is_op(op, OP_LH))  return {{16{d[15]}}, d[15:0]};
        if (is_op(op, OP_LBU)) return {24'b0, d[7:0]};
        if (is_op(op, OP_LHU)) return {16'b0, d[15:0]};
        return d;
    endfunction

    // NOTE: every field gets a default before the case so no path leaves a latch.
    always_comb begin
        state_d     = state;
        r_d         = r;
        r_d.end_pulse = 1'b0;
        r_d.cdb_en    = 1'b0;
        r_d.cdb_fault = 1'b0;
        is_load     = r.mem_rw;

        unique case (state)
            IDLE: begin
                if (bus.enable_from_lsb && !bus.rollback_flag_from_rob) begin
                    r_d.busy     = 1'b1;
                    r_d.op       = bus.op_enum_from_lsb;
                    r_d.tag      = bus.rob_tag_from_lsb;
                    r_d.mem_rw   = bus.read_write_flag_from_lsb;
                    r_d.mem_addr = bus.object_address_from_lsb;
                    r_d.mem_size = size_of(bus.op_enum_from_lsb);
                    r_d.mem_data = store_ext(bus.op_enum_from_lsb, bus.data_from_lsb);
                    if (MISALIGN_CHECK != 0 &&
                        misaligned(bus.op_enum_from_lsb, bus.object_address_from_lsb[1:0])) begin
                        state_d = FAULT;
                    end else begin
                        state_d    = ACCESS;
                        r_d.mem_en = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (bus.end_from_memcont) begin
                    state_d    = IDLE;
                    r_d.mem_en = 1'b0;
                    r_d.busy   = 1'b0;
                    // A load flushed on the very completion edge is dropped silently.
                    if (!(is_load && bus.rollback_flag_from_rob)) begin
                        r_d.end_pulse = 1'b1;
                        if (is_load) begin
                            r_d.cdb_en      = 1'b1;
                            r_d.cdb_tag     = r.tag;
                            r_d.cdb_result  = load_ext(r.op, bus.data_from_memcont);
                            r_d.data_to_lsb = load_ext(r.op, bus.data_from_memcont);
                        end
                    end
                end else if (is_load && bus.rollback_flag_from_rob) begin
                    state_d = KILL;
                end
            end
            KILL: begin
                if (bus.end_from_memcont) begin
                    state_d    = IDLE;
                    r_d.mem_en = 1'b0;
                    r_d.busy   = 1'b0;
                end
            end
            FAULT: begin
                state_d  = IDLE;
                r_d.busy = 1'b0;
                if (!(is_load && bus.rollback_flag_from_rob)) begin
                    r_d.end_pulse  = 1'b1;
                    r_d.cdb_en     = 1'b1;
                    r_d.cdb_fault  = 1'b1;
                    r_d.cdb_tag    = r.tag;
                    r_d.cdb_result = 32'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking updates; rdy_in low freezes everything, pulses included.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
            r     <= '0;
        end else if (rdy_in) begin
            state <= state_d;
            r     <= r_d;
        end
    end

    assign bus.busy_to_lsb                = r.busy;
    assign bus.end_to_lsb                 = r.end_pulse;
    assign bus.data_to_lsb                = r.data_to_lsb;
    assign bus.enable_to_memcont          = r.mem_en;
    assign bus.read_write_flag_to_memcont = r.mem_rw;
    assign bus.address_to_memcont         = r.mem_addr;
    assign bus.size_to_memcont            = r.mem_size;
    assign bus.data_to_memcont            = r.mem_data;
    assign bus.enable_to_cdb              = r.cdb_en;
    assign bus.result_to_cdb              = r.cdb_result;
    assign bus.rob_tag_to_cdb             = r.cdb_tag;
    assign bus.fault_to_cdb               = r.cdb_fault;
endmodule
